// File: rtl/mipi_csi_rx_packet_sequencer_2lane.sv
// mipi_csi_rx_packet_sequencer_2lane
//
// Packet sequencer for a 2-lane CSI-2 receiver. It sits ahead of
// mipi_csi_rx_raw_depacker_8b2lane_2ppc and does four jobs:
//   - parses the 4-byte packet header from the lane-aligned 16-bit stream;
//   - turns short packets into frame/line strobes;
//   - forwards exactly ceil(WC/2) payload beats of accepted RAW long packets,
//     together with the depacker packet type;
//   - strips the CRC beat and waits for end of transmission.
//
// Parameters
//   VC_SEL          virtual channel whose long packets are forwarded
//   WC_MAX          largest legal word count in bytes
//
// Ports
//   clk_i           byte clock, shared with the depacker
//   reset_i         synchronous reset, active-high
//   data_valid_i    high from the first header byte until EoT
//   data_i          [7:0] lane 0 byte (earlier), [15:8] lane 1 byte
//   payload_valid_o registered beat valid towards the depacker
//   payload_o       registered beat data towards the depacker
//   packet_type_o   DT - 0x28 of the last accepted RAW long header
//   vc_o            VC of the last decoded header
//   word_count_o    WC of the last decoded header
//   frame_start_o   single-cycle pulse on a frame start short packet
//   frame_end_o     single-cycle pulse on a frame end short packet
//   line_start_o    single-cycle pulse on a line start short packet
//   line_end_o      single-cycle pulse on a line end short packet
//   busy_o          high whenever the sequencer is not idle
//   hdr_error_o     single-cycle pulse on an illegal word count
//   truncated_o     single-cycle pulse when data_valid_i drops mid-packet

module mipi_csi_rx_packet_sequencer_2lane #(
  parameter logic [1:0]  VC_SEL = 2'd0,
  parameter logic [15:0] WC_MAX = 16'd8192
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        data_valid_i,
  input  logic [15:0] data_i,
  output logic        payload_valid_o,
  output logic [15:0] payload_o,
  output logic [2:0]  packet_type_o,
  output logic [1:0]  vc_o,
  output logic [15:0] word_count_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        busy_o,
  output logic        hdr_error_o,
  output logic        truncated_o
);

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    PAYLOAD,
    CRC,
    DROP,
    WAIT_END
  } state_t;

  // Data type codes for the short packets that produce strobes.
  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_LINE_START  = 6'h02;
  localparam logic [5:0] DT_LINE_END    = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX   = 6'h0F;

  // RAW8..RAW14 is the range the depacker understands.
  localparam logic [5:0] DT_RAW_MIN     = 6'h2A;
  localparam logic [5:0] DT_RAW_MAX     = 6'h2D;

  state_t      state_q;
  logic [7:0]  di_q;
  logic [7:0]  wc_lo_q;
  logic [15:0] beat_cnt_q;

  logic [15:0] hdr_wc;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_beats;
  logic        hdr_short;
  logic        hdr_wc_bad;
  logic        hdr_raw;
  logic        hdr_vc_ok;
  logic        last_beat;

  // Header decode, only meaningful in HDR1 where data_i carries WC[15:8]
  // in lane 0 (the ECC byte in lane 1 is not checked).
  always_comb begin
    hdr_wc     = {data_i[7:0], wc_lo_q};
    hdr_dt     = di_q[5:0];
    hdr_vc     = di_q[7:6];
    // Two bytes per beat; an odd WC still needs a whole final beat.
    hdr_beats  = {1'b0, hdr_wc[15:1]} + {15'd0, hdr_wc[0]};
    hdr_short  = (hdr_dt <= DT_SHORT_MAX);
    hdr_wc_bad = (hdr_wc == 16'd0) || (hdr_wc > WC_MAX);
    hdr_raw    = (hdr_dt >= DT_RAW_MIN) && (hdr_dt <= DT_RAW_MAX);
    hdr_vc_ok  = (hdr_vc == VC_SEL);
    last_beat  = (beat_cnt_q == 16'd1);
  end

  assign busy_o = (state_q != IDLE);

  // Sequencer FSM with all outputs registered. Strobes and payload_valid_o
  // default low every cycle so they can only ever be one-cycle pulses or a
  // contiguous burst driven from PAYLOAD.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      di_q            <= 8'd0;
      wc_lo_q         <= 8'd0;
      beat_cnt_q      <= 16'd0;
      payload_valid_o <= 1'b0;
      payload_o       <= 16'd0;
      packet_type_o   <= 3'd0;
      vc_o            <= 2'd0;
      word_count_o    <= 16'd0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_start_o    <= 1'b0;
      line_end_o      <= 1'b0;
      hdr_error_o     <= 1'b0;
      truncated_o     <= 1'b0;
    end else begin
      payload_valid_o <= 1'b0;
      frame_start_o   <= 1'b0;
      frame_end_o     <= 1'b0;
      line_start_o    <= 1'b0;
      line_end_o      <= 1'b0;
      hdr_error_o     <= 1'b0;
      truncated_o     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (data_valid_i) begin
            di_q    <= data_i[7:0];
            wc_lo_q <= data_i[15:8];
            state_q <= HDR1;
          end
        end

        HDR1: begin
          if (!data_valid_i) begin
            truncated_o <= 1'b1;
            state_q     <= IDLE;
          end else begin
            vc_o         <= hdr_vc;
            word_count_o <= hdr_wc;
            if (hdr_short) begin
              frame_start_o <= (hdr_dt == DT_FRAME_START);
              frame_end_o   <= (hdr_dt == DT_FRAME_END);
              line_start_o  <= (hdr_dt == DT_LINE_START);
              line_end_o    <= (hdr_dt == DT_LINE_END);
              state_q       <= WAIT_END;
            end else if (hdr_wc_bad) begin
              hdr_error_o <= 1'b1;
              state_q     <= WAIT_END;
            end else if (!hdr_raw || !hdr_vc_ok) begin
              // Legal but unwanted long packet: skip its payload silently.
              beat_cnt_q <= hdr_beats;
              state_q    <= DROP;
            end else begin
              // 0x2A..0x2D share bits [5:3], so DT - 0x28 is just DT[2:0].
              packet_type_o <= hdr_dt[2:0];
              beat_cnt_q    <= hdr_beats;
              state_q       <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (!data_valid_i) begin
            truncated_o <= 1'b1;
            state_q     <= IDLE;
          end else begin
            payload_valid_o <= 1'b1;
            payload_o       <= data_i;
            beat_cnt_q      <= beat_cnt_q - 16'd1;
            if (last_beat) begin
              state_q <= CRC;
            end
          end
        end

        DROP: begin
          if (!data_valid_i) begin
            truncated_o <= 1'b1;
            state_q     <= IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q - 16'd1;
            if (last_beat) begin
              state_q <= CRC;
            end
          end
        end

        CRC: begin
          if (!data_valid_i) begin
            truncated_o <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= WAIT_END;
          end
        end

        WAIT_END: begin
          // Trailer bytes are swallowed until the lanes go quiet.
          if (!data_valid_i) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_packet_sequencer_2lane.sv
// tb_mipi_csi_rx_packet_sequencer_2lane
//
// Directed self-checking bench for mipi_csi_rx_packet_sequencer_2lane.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after
// the following rising edge, so each check sees the registered response to
// the beat just applied.

module tb_mipi_csi_rx_packet_sequencer_2lane;

  logic        clk_i;
  logic        reset_i;
  logic        data_valid_i;
  logic [15:0] data_i;
  logic        payload_valid_o;
  logic [15:0] payload_o;
  logic [2:0]  packet_type_o;
  logic [1:0]  vc_o;
  logic [15:0] word_count_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        line_end_o;
  logic        busy_o;
  logic        hdr_error_o;
  logic        truncated_o;

  int total = 0;
  int bad   = 0;

  mipi_csi_rx_packet_sequencer_2lane dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .data_valid_i    (data_valid_i),
    .data_i          (data_i),
    .payload_valid_o (payload_valid_o),
    .payload_o       (payload_o),
    .packet_type_o   (packet_type_o),
    .vc_o            (vc_o),
    .word_count_o    (word_count_o),
    .frame_start_o   (frame_start_o),
    .frame_end_o     (frame_end_o),
    .line_start_o    (line_start_o),
    .line_end_o      (line_end_o),
    .busy_o          (busy_o),
    .hdr_error_o     (hdr_error_o),
    .truncated_o     (truncated_o)
  );

  // 100 MHz byte clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one beat, then step to 1 ns past the edge that samples it.
  task automatic applyStimulus(input logic v, input logic [15:0] d);
    data_valid_i = v;
    data_i       = d;
    @(posedge clk_i);
    #1;
  endtask

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Short packet: two header beats, then valid low. exp is {FS,FE,LS,LE}.
  task automatic sendShort(input string tag, input logic [15:0] h0,
                           input logic [3:0] exp);
    applyStimulus(1'b1, h0);
    checkOutput({tag, "_h0_strobes"}, {frame_start_o, frame_end_o, line_start_o, line_end_o}, 4'b0000);
    checkOutput({tag, "_h0_busy"}, busy_o, 1'b1);
    applyStimulus(1'b1, 16'hEC00);
    checkOutput({tag, "_strobes"}, {frame_start_o, frame_end_o, line_start_o, line_end_o}, exp);
    checkOutput({tag, "_pv"}, payload_valid_o, 1'b0);
    applyStimulus(1'b0, 16'h0000);
    checkOutput({tag, "_strobes_off"}, {frame_start_o, frame_end_o, line_start_o, line_end_o}, 4'b0000);
    checkOutput({tag, "_idle"}, busy_o, 1'b0);
  endtask

  // Accepted RAW long packet up to and including the CRC beat.
  task automatic sendRaw(input string tag, input logic [15:0] h0, input logic [15:0] h1,
                         input int beats, input logic [2:0] ptype, input logic [15:0] wc,
                         input logic [15:0] seed);
    int pv_seen;
    logic [15:0] d;
    pv_seen = 0;
    applyStimulus(1'b1, h0);
    applyStimulus(1'b1, h1);
    checkOutput({tag, "_hdr_pv"}, payload_valid_o, 1'b0);
    checkOutput({tag, "_ptype"}, packet_type_o, ptype);
    checkOutput({tag, "_wc"}, word_count_o, wc);
    checkOutput({tag, "_hdr_err"}, hdr_error_o, 1'b0);
    for (int i = 0; i < beats; i++) begin
      d = seed + 16'(i * 16'h0101);
      applyStimulus(1'b1, d);
      if (payload_valid_o) pv_seen++;
      checkOutput({tag, "_beat"}, {payload_valid_o, payload_o}, {1'b1, d});
      checkOutput({tag, "_beat_ptype"}, packet_type_o, ptype);
    end
    checkOutput({tag, "_beat_count"}, pv_seen, beats);
    applyStimulus(1'b1, 16'hC5C5);
    checkOutput({tag, "_crc_pv"}, payload_valid_o, 1'b0);
    checkOutput({tag, "_crc_busy"}, busy_o, 1'b1);
  endtask

  initial begin
    reset_i      = 1'b1;
    data_valid_i = 1'b0;
    data_i       = 16'h0000;
    applyStimulus(1'b0, 16'h0000);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("rst_pv", payload_valid_o, 1'b0);
    checkOutput("rst_payload", payload_o, 16'h0000);
    checkOutput("rst_ptype", packet_type_o, 3'd0);
    checkOutput("rst_vc_wc", {vc_o, word_count_o}, 18'd0);
    checkOutput("rst_flags", {frame_start_o, frame_end_o, line_start_o, line_end_o,
                              busy_o, hdr_error_o, truncated_o}, 7'd0);
    reset_i = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    checkOutput("post_rst_busy", busy_o, 1'b0);

    $display("[TB] frame start short packet");
    sendShort("fs", 16'h0000, 4'b1000);

    $display("[TB] RAW12 WC=30 with trailer");
    sendRaw("raw12", 16'h1E2C, 16'hA500, 15, 3'd4, 16'd30, 16'h0201);
    applyStimulus(1'b1, 16'hFFFF);
    checkOutput("raw12_trl1_pv", payload_valid_o, 1'b0);
    applyStimulus(1'b1, 16'hFFFF);
    checkOutput("raw12_trl2_pv", payload_valid_o, 1'b0);
    checkOutput("raw12_trl2_busy", busy_o, 1'b1);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("raw12_idle", busy_o, 1'b0);

    $display("[TB] RAW10 odd WC=5");
    sendRaw("raw10", 16'h052B, 16'h3300, 3, 3'd3, 16'd5, 16'h1122);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("raw10_idle", busy_o, 1'b0);

    $display("[TB] DT=0x12 on VC=1 is dropped");
    applyStimulus(1'b1, 16'h0452);
    applyStimulus(1'b1, 16'h0000);
    checkOutput("drop_vc", vc_o, 2'd1);
    checkOutput("drop_wc", word_count_o, 16'd4);
    checkOutput("drop_hdr_err", hdr_error_o, 1'b0);
    checkOutput("drop_ptype_held", packet_type_o, 3'd3);
    applyStimulus(1'b1, 16'hAAAA);
    checkOutput("drop_b1_pv", payload_valid_o, 1'b0);
    applyStimulus(1'b1, 16'hBBBB);
    checkOutput("drop_b2_pv", payload_valid_o, 1'b0);
    applyStimulus(1'b1, 16'hC5C5);
    checkOutput("drop_crc_busy", {busy_o, payload_valid_o, hdr_error_o}, 3'b100);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("drop_idle", busy_o, 1'b0);
    sendShort("fs2", 16'h0000, 4'b1000);
    sendShort("fe", 16'h0001, 4'b0100);
    sendShort("ls", 16'h0002, 4'b0010);
    sendShort("le", 16'h0003, 4'b0001);
    sendShort("sp8", 16'h0008, 4'b0000);

    $display("[TB] word count limits");
    applyStimulus(1'b1, 16'h002C);
    applyStimulus(1'b1, 16'h0000);
    checkOutput("wc0_err", hdr_error_o, 1'b1);
    checkOutput("wc0_busy", busy_o, 1'b1);
    applyStimulus(1'b1, 16'h1234);
    checkOutput("wc0_err_pulse", {hdr_error_o, busy_o, payload_valid_o}, 3'b010);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("wc0_idle", busy_o, 1'b0);
    applyStimulus(1'b1, 16'h012C);
    applyStimulus(1'b1, 16'h0020);
    checkOutput("wc8193_err", hdr_error_o, 1'b1);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("wc8193_idle", busy_o, 1'b0);
    applyStimulus(1'b1, 16'h002C);
    applyStimulus(1'b1, 16'h0020);
    checkOutput("wc8192_err", hdr_error_o, 1'b0);
    checkOutput("wc8192_wc", word_count_o, 16'd8192);
    checkOutput("wc8192_busy", busy_o, 1'b1);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("wc8192_trunc", {truncated_o, payload_valid_o, busy_o}, 3'b100);

    $display("[TB] truncation after 4 of 15 beats");
    applyStimulus(1'b1, 16'h1E2C);
    applyStimulus(1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h4000 + 16'(i));
      checkOutput("trunc_beat", {payload_valid_o, payload_o}, {1'b1, 16'h4000 + 16'(i)});
    end
    applyStimulus(1'b0, 16'h0000);
    checkOutput("trunc_pulse", truncated_o, 1'b1);
    checkOutput("trunc_pv", payload_valid_o, 1'b0);
    checkOutput("trunc_busy", busy_o, 1'b0);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("trunc_pulse_off", truncated_o, 1'b0);
    sendRaw("raw8", 16'h042A, 16'h0000, 2, 3'd2, 16'd4, 16'h5A01);
    applyStimulus(1'b0, 16'h0000);
    checkOutput("raw8_idle", busy_o, 1'b0);

    $display("[TB] reset during payload");
    applyStimulus(1'b1, 16'h0A2D);
    applyStimulus(1'b1, 16'h0000);
    checkOutput("raw14_ptype", packet_type_o, 3'd5);
    applyStimulus(1'b1, 16'h6001);
    applyStimulus(1'b1, 16'h6002);
    checkOutput("raw14_beat2", {payload_valid_o, payload_o}, {1'b1, 16'h6002});
    reset_i = 1'b1;
    applyStimulus(1'b1, 16'h6003);
    checkOutput("mid_rst_pv", payload_valid_o, 1'b0);
    checkOutput("mid_rst_payload", payload_o, 16'h0000);
    checkOutput("mid_rst_ptype", packet_type_o, 3'd0);
    checkOutput("mid_rst_vc_wc", {vc_o, word_count_o}, 18'd0);
    checkOutput("mid_rst_busy", busy_o, 1'b0);
    reset_i = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    checkOutput("post_mid_rst_idle", {busy_o, payload_valid_o, truncated_o}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
